// File: rtl/if_fetch.sv
// Instruction-fetch front end: owns the PC, issues imem requests under a credit limit and queues
// returned words for IF/ID. Define FETCH_BYPASS_EN to forward a response straight to the output when the FIFO is empty.
`timescale 1ns/1ps

`ifndef INST_NOP_OP
`define INST_NOP_OP 32'h0000_0013
`endif

module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        jump_en_i,
    input  logic [31:0] jump_addr_i,
    input  logic        hold_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] inst_o,
    output logic [31:0] inst_addr_o,
    output logic        inst_valid_o
);
    localparam int AW  = $clog2(DEPTH);
    localparam int CW  = AW + 1;
    localparam int CW1 = CW + 1;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } fetch_ent_t;

    logic [31:0]               pc_q;
    logic [CW-1:0]             outstanding, discard_cnt, fifo_count;
    logic [DEPTH-1:0][31:0]    aq_mem;
    logic [AW-1:0]             aq_wptr, aq_rptr;
    fetch_ent_t [DEPTH-1:0]    fifo_mem;
    logic [AW-1:0]             fifo_wptr, fifo_rptr;

    logic [CW1-1:0] credit_used;
    logic           grant, resp_keep, push, pop, fifo_pop, fifo_empty;
    fetch_ent_t     resp_ent, out_ent;
    logic           unused_jump_lsb;

    assign unused_jump_lsb = ^jump_addr_i[1:0];

    // Outstanding requests plus buffered words may never exceed DEPTH, so the FIFO cannot overflow.
    assign credit_used = {1'b0, outstanding} + {1'b0, fifo_count};
    assign imem_req_o  = !rst && !jump_en_i && (credit_used < CW1'(DEPTH));
    assign imem_addr_o = pc_q;
    assign grant       = imem_req_o && imem_gnt_i;

    assign fifo_empty = (fifo_count == '0);
    assign resp_keep  = imem_rvalid_i && !jump_en_i && (discard_cnt == '0);
    assign resp_ent   = '{addr: aq_mem[aq_rptr], data: imem_rdata_i};

`ifdef FETCH_BYPASS_EN
    logic bypass_hit;
    assign bypass_hit   = fifo_empty && resp_keep;
    assign out_ent      = bypass_hit ? resp_ent : fifo_mem[fifo_rptr];
    assign inst_valid_o = !jump_en_i && (!fifo_empty || bypass_hit);
    assign push         = resp_keep && !(bypass_hit && !hold_i);
`else
    assign out_ent      = fifo_mem[fifo_rptr];
    assign inst_valid_o = !jump_en_i && !fifo_empty;
    assign push         = resp_keep;
`endif

    assign pop      = inst_valid_o && !hold_i;
    assign fifo_pop = pop && !fifo_empty;

    assign inst_o      = inst_valid_o ? out_ent.data : `INST_NOP_OP;
    assign inst_addr_o = inst_valid_o ? out_ent.addr : 32'h0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q        <= RESET_PC;
            outstanding <= '0;
            discard_cnt <= '0;
            aq_wptr     <= '0;
            aq_rptr     <= '0;
            fifo_wptr   <= '0;
            fifo_rptr   <= '0;
            fifo_count  <= '0;
        end else begin
            if (jump_en_i)
                pc_q <= {jump_addr_i[31:2], 2'b00};
            else if (grant)
                pc_q <= pc_q + 32'd4;

            outstanding <= outstanding + CW'(grant) - CW'(imem_rvalid_i);

            // Everything still in flight after a redirect is stale; the address queue keeps pairing it.
            if (jump_en_i)
                discard_cnt <= outstanding - CW'(imem_rvalid_i);
            else if (imem_rvalid_i && discard_cnt != '0)
                discard_cnt <= discard_cnt - CW'(1);

            if (grant)         aq_wptr <= aq_wptr + AW'(1);
            if (imem_rvalid_i) aq_rptr <= aq_rptr + AW'(1);

            if (jump_en_i) begin
                fifo_wptr  <= '0;
                fifo_rptr  <= '0;
                fifo_count <= '0;
            end else begin
                if (push)     fifo_wptr <= fifo_wptr + AW'(1);
                if (fifo_pop) fifo_rptr <= fifo_rptr + AW'(1);
                fifo_count <= fifo_count + CW'(push) - CW'(fifo_pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (grant) aq_mem[aq_wptr]     <= pc_q;
        if (push)  fifo_mem[fifo_wptr] <= resp_ent;
    end

    a_no_resp_when_full: assert property (@(posedge clk) disable iff (rst)
        !(imem_rvalid_i && fifo_count == CW'(DEPTH)));

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: streaming, stall, grant wait, redirects and async reset against a zero-wait memory.
`timescale 1ns/1ps

module tb_if_fetch;
    localparam logic [31:0] K   = 32'hA5A5_0000;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        jump_en_i, hold_i, imem_gnt_i, imem_rvalid_i;
    logic [31:0] jump_addr_i, imem_rdata_i;
    logic        imem_req_o, inst_valid_o;
    logic [31:0] imem_addr_o, inst_o, inst_addr_o;

    if_fetch #(.RESET_PC(32'h0), .DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .jump_en_i(jump_en_i), .jump_addr_i(jump_addr_i), .hold_i(hold_i),
        .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
        .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
        .inst_o(inst_o), .inst_addr_o(inst_addr_o), .inst_valid_o(inst_valid_o)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    logic rsp_en;
    logic [31:0] gq[$];

    // stream + stall phase, cycles C0..C15 (hold_i high in C5..C9)
    logic        s_req  [16] = '{1,1,1,1,1,1,1,0,0,0,0,1,1,1,1,1};
    logic [31:0] s_addr [16] = '{32'h0,32'h4,32'h8,32'hC,32'h10,32'h14,32'h18,32'h1C,
                                 32'h1C,32'h1C,32'h1C,32'h1C,32'h20,32'h24,32'h28,32'h2C};
    logic        s_vld  [16] = '{0,0,1,1,1,1,1,1,1,1,1,1,1,1,1,1};
    logic [31:0] s_ia   [16] = '{32'h0,32'h0,32'h0,32'h4,32'h8,32'hC,32'hC,32'hC,
                                 32'hC,32'hC,32'hC,32'h10,32'h14,32'h18,32'h1C,32'h20};

    // post-reset phase D0..D15: grant wait, redirect to 0x100, misaligned redirect to 0x203
    logic        d_gnt  [16] = '{1,1,0,0,0,1,1,1,1,1,1,1,1,1,1,1};
    logic        d_rsp  [16] = '{1,1,1,1,1,0,0,1,1,1,1,1,1,1,1,1};
    logic        d_jmp  [16] = '{0,0,0,0,0,0,0,1,0,0,0,0,1,0,0,0};
    logic        d_req  [16] = '{1,1,1,1,1,1,1,0,1,1,1,1,0,1,1,1};
    logic [31:0] d_addr [16] = '{32'h0,32'h4,32'h8,32'h8,32'h8,32'h8,32'hC,32'h10,
                                 32'h100,32'h104,32'h108,32'h10C,32'h110,32'h200,32'h204,32'h208};
    logic        d_vld  [16] = '{0,0,1,1,0,0,0,0,0,0,0,1,0,0,0,1};
    logic [31:0] d_ia   [16] = '{32'h0,32'h0,32'h0,32'h4,32'h0,32'h0,32'h0,32'h0,
                                 32'h0,32'h0,32'h0,32'h100,32'h0,32'h0,32'h0,32'h200};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Advance one clock; zero-wait memory answers a grant in the following cycle when rsp_en is set.
    task automatic tick();
        logic        g;
        logic [31:0] a;
        g = imem_req_o && imem_gnt_i;
        a = imem_addr_o;
        @(posedge clk); #1;
        if (g) gq.push_back(a);
        if (rsp_en && gq.size() > 0) begin
            imem_rvalid_i = 1'b1;
            imem_rdata_i  = gq.pop_front() ^ K;
        end else begin
            imem_rvalid_i = 1'b0;
            imem_rdata_i  = 32'h0;
        end
    endtask

    task automatic check_out(input string ph, input int c, input logic req, input logic [31:0] addr,
                             input logic vld, input logic [31:0] ia);
        check($sformatf("%s%0d req", ph, c), imem_req_o, req);
        check($sformatf("%s%0d addr", ph, c), imem_addr_o, addr);
        check($sformatf("%s%0d valid", ph, c), inst_valid_o, vld);
        check($sformatf("%s%0d inst_addr", ph, c), inst_addr_o, ia);
        check($sformatf("%s%0d inst", ph, c), inst_o, vld ? (ia ^ K) : NOP);
    endtask

    initial begin
        rst = 1'b1; jump_en_i = 1'b0; jump_addr_i = 32'h0; hold_i = 1'b0;
        imem_gnt_i = 1'b1; imem_rvalid_i = 1'b0; imem_rdata_i = 32'h0; rsp_en = 1'b1;
        #2;
        check("rst req", imem_req_o, 1'b0);
        check("rst valid", inst_valid_o, 1'b0);
        check("rst inst", inst_o, NOP);
        check("rst inst_addr", inst_addr_o, 32'h0);

        tick();
        rst = 1'b0;
        for (int c = 0; c < 16; c++) begin
            if (c != 0) tick();
            hold_i = (c >= 5 && c <= 9);
            #1;
            check_out("C", c, s_req[c], s_addr[c], s_vld[c], s_ia[c]);
        end

        // async reset between edges while the FIFO holds data
        tick();
        #2;
        rst = 1'b1;
        #1;
        check("arst valid", inst_valid_o, 1'b0);
        check("arst inst", inst_o, NOP);
        check("arst inst_addr", inst_addr_o, 32'h0);
        check("arst req", imem_req_o, 1'b0);
        gq.delete();
        imem_rvalid_i = 1'b0;
        tick();
        rst = 1'b0;

        for (int c = 0; c < 16; c++) begin
            if (c != 0) tick();
            imem_gnt_i  = d_gnt[c];
            jump_en_i   = d_jmp[c];
            jump_addr_i = (c == 7) ? 32'h100 : (c == 12) ? 32'h203 : 32'h0;
            rsp_en      = d_rsp[c];
            #1;
            check_out("D", c, d_req[c], d_addr[c], d_vld[c], d_ia[c]);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
